event_buffer_tracker: RTL and testbench

- Sits directly downstream of the event completion tracker in the aclk domain of the event path.
- Owns a ring of 2**NBUF_BITS event buffers and allocates them in order when triggers are accepted.
- Marks the oldest filling buffer complete on each completion pulse, capturing the tracker's error vector with it.
- Presents completed buffer indices to readout over an AXI4-Stream handshake and reclaims buffers in order when readout reports them freed.

---
 rtl/event_pkg.sv | 17 +
 rtl/event_buffer_tracker.sv | 108 ++++++++++
 tb/tb_event_buffer_tracker.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/event_pkg.sv
// Shared constants for the event buffer tracker: ring sizing, stream beat layout
// and sticky status flag positions.
package event_pkg;

    localparam int NBUF_BITS_DEFAULT = 2;
    localparam int TIO_ERR_W         = 4;

    localparam int TDATA_W = 8;
    localparam int ERR_LSB = 4;
    localparam int IDX_LSB = 0;

    localparam int ST_W          = 3;
    localparam int ST_ALLOC_FULL = 0;
    localparam int ST_CMP_EMPTY  = 1;
    localparam int ST_FREE_UNDER = 2;

endpackage

// File: rtl/event_buffer_tracker.sv
// Ring of event buffers: allocate on trigger, complete in order with the tracker's
// error vector, stream completed indices to readout, reclaim on free.
module event_buffer_tracker
    import event_pkg::*;
#(
    parameter int    NBUF_BITS = NBUF_BITS_DEFAULT,
    parameter string ACLKTYPE  = "NONE"
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   alloc_i,
    output logic                   alloc_ready_o,
    output logic [NBUF_BITS-1:0]   alloc_idx_o,
    input  logic                   complete_i,
    input  logic [TIO_ERR_W-1:0]   err_i,
    output logic [TDATA_W-1:0]     m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    input  logic                   free_i,
    output logic [NBUF_BITS:0]     occupancy_o,
    output logic [ST_W-1:0]        status_err_o
);

    localparam int            PW   = NBUF_BITS + 1;
    localparam int            NBUF = 1 << NBUF_BITS;
    localparam logic [PW-1:0] FULL = PW'(NBUF);

    if (NBUF_BITS < 1 || NBUF_BITS > 4 || ACLKTYPE == "") begin : g_bad_param
        $error("event_buffer_tracker: NBUF_BITS must be 1..4 and ACLKTYPE non-empty");
    end

    logic [PW-1:0]        wr_q, wr_d, cmp_q, cmp_d, rd_q, rd_d, fr_q, fr_d;
    logic [PW-1:0]        occ;
    logic                 alloc_ok, complete_ok, xfer, free_ok;
    logic                 ready_q, ready_d;
    logic                 tvalid_q, tvalid_d;
    logic [TDATA_W-1:0]   tdata_q, tdata_d;
    logic [TIO_ERR_W-1:0] err_sel;
    logic [ST_W-1:0]      status_q, status_d;
    logic [TIO_ERR_W-1:0] errmem_q [NBUF];

    assign occ         = wr_q - fr_q;
    assign alloc_ok    = alloc_i && (occ != FULL);
    // A complete on an empty filling region is legal when it targets the buffer allocated now.
    assign complete_ok = complete_i && ((cmp_q != wr_q) || alloc_ok);
    assign xfer        = tvalid_q && m_axis_tready;
    assign free_ok     = free_i && (fr_q != rd_q);

    always_comb begin
        wr_d  = wr_q  + PW'(alloc_ok);
        cmp_d = cmp_q + PW'(complete_ok);
        rd_d  = rd_q  + PW'(xfer);
        fr_d  = fr_q  + PW'(free_ok);
    end

    always_comb begin
        ready_d  = (wr_d - fr_d) != FULL;
        tvalid_d = (cmp_d != rd_d);
        // The head beat may be the buffer completing this cycle, before errmem holds it.
        err_sel  = (complete_ok && (rd_d == cmp_q)) ? err_i : errmem_q[rd_d[NBUF_BITS-1:0]];
        tdata_d  = '0;
        if (tvalid_d) begin
            tdata_d[ERR_LSB +: TIO_ERR_W] = err_sel;
            tdata_d[IDX_LSB +: NBUF_BITS] = rd_d[NBUF_BITS-1:0];
        end
    end

    always_comb begin
        status_d = status_q;
        if (alloc_i && !alloc_ok)       status_d[ST_ALLOC_FULL] = 1'b1;
        if (complete_i && !complete_ok) status_d[ST_CMP_EMPTY]  = 1'b1;
        if (free_i && !free_ok)         status_d[ST_FREE_UNDER] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_q     <= '0;
            cmp_q    <= '0;
            rd_q     <= '0;
            fr_q     <= '0;
            ready_q  <= 1'b1;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            status_q <= '0;
        end else begin
            wr_q     <= wr_d;
            cmp_q    <= cmp_d;
            rd_q     <= rd_d;
            fr_q     <= fr_d;
            ready_q  <= ready_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (complete_ok) errmem_q[cmp_q[NBUF_BITS-1:0]] <= err_i;
    end

    assign alloc_ready_o = ready_q;
    assign alloc_idx_o   = wr_q[NBUF_BITS-1:0];
    assign occupancy_o   = occ;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign status_err_o  = status_q;

endmodule

// File: tb/tb_event_buffer_tracker.sv
// Scenario bench for event_buffer_tracker: expected beats are queued as completes
// are driven and checked by a monitor as the stream hands them out.
module tb_event_buffer_tracker;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       alloc_i, complete_i, free_i, m_axis_tready;
    logic [3:0] err_i;
    logic       alloc_ready_o, m_axis_tvalid;
    logic [1:0] alloc_idx_o;
    logic [7:0] m_axis_tdata;
    logic [2:0] occupancy_o;
    logic [2:0] status_err_o;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    event_buffer_tracker #(.NBUF_BITS(2), .ACLKTYPE("NONE")) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .alloc_i       (alloc_i),
        .alloc_ready_o (alloc_ready_o),
        .alloc_idx_o   (alloc_idx_o),
        .complete_i    (complete_i),
        .err_i         (err_i),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .free_i        (free_i),
        .occupancy_o   (occupancy_o),
        .status_err_o  (status_err_o)
    );

    always #5 aclk = ~aclk;

    // Inputs change 2 time units after posedge, so at negedge they are stable for the next edge.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL beat_unexpected: got tdata=%h, expected no beat", m_axis_tdata);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_axis_tdata !== e) begin
                    n_fail++;
                    $display("FAIL beat_tdata: got %h, expected %h", m_axis_tdata, e);
                end
            end
        end
    end

    function automatic logic [7:0] beat(input logic [3:0] err, input logic [1:0] idx);
        return {err, 2'b00, idx};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #2;
        alloc_i    = 1'b0;
        complete_i = 1'b0;
        free_i     = 1'b0;
    endtask

    task automatic do_reset();
        m_axis_tready = 1'b0;
        aresetn = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        exp_q.delete();
        tick();
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d beats still pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        alloc_i = 1'b0; complete_i = 1'b0; free_i = 1'b0;
        err_i = 4'h0; m_axis_tready = 1'b0;
        tick(); tick(); tick();
        aresetn = 1'b1;
        tick();
        n_cmp += 6;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b, expected 0", m_axis_tvalid); end
        if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL rst_tdata: got %h, expected 00", m_axis_tdata); end
        if (alloc_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, expected 1", alloc_ready_o); end
        if (occupancy_o !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d, expected 0", occupancy_o); end
        if (status_err_o !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b, expected 000", status_err_o); end
        if (alloc_idx_o !== 2'd0) begin n_fail++; $display("FAIL rst_idx: got %0d, expected 0", alloc_idx_o); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (alloc_idx_o !== 2'(i)) begin n_fail++; $display("FAIL fill_idx: got %0d, expected %0d", alloc_idx_o, i); end
            alloc_i = 1'b1;
            tick();
        end
        n_cmp += 2;
        if (occupancy_o !== 3'd4) begin n_fail++; $display("FAIL fill_occ: got %0d, expected 4", occupancy_o); end
        if (alloc_ready_o !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b, expected 0", alloc_ready_o); end
        alloc_i = 1'b1;
        tick();
        n_cmp += 2;
        if (status_err_o !== 3'b001) begin n_fail++; $display("FAIL fill_overflow_flag: got %b, expected 001", status_err_o); end
        if (occupancy_o !== 3'd4) begin n_fail++; $display("FAIL fill_overflow_occ: got %0d, expected 4", occupancy_o); end
    endtask

    task automatic test_stream();
        do_reset();
        m_axis_tready = 1'b1;
        alloc_i = 1'b1; tick();
        alloc_i = 1'b1; tick();
        complete_i = 1'b1; err_i = 4'h0; exp_q.push_back(8'h00); tick();
        complete_i = 1'b1; err_i = 4'h6; exp_q.push_back(8'h61); tick();
        wait_drain(10);
        free_i = 1'b1; tick();
        free_i = 1'b1; tick();
        n_cmp += 2;
        if (occupancy_o !== 3'd0) begin n_fail++; $display("FAIL stream_occ: got %0d, expected 0", occupancy_o); end
        if (status_err_o !== 3'b000) begin n_fail++; $display("FAIL stream_status: got %b, expected 000", status_err_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        alloc_i = 1'b1; tick();
        alloc_i = 1'b1; tick();
        complete_i = 1'b1; err_i = 4'h0; exp_q.push_back(8'h00); tick();
        complete_i = 1'b1; err_i = 4'h3; exp_q.push_back(8'h31); tick();
        for (int i = 0; i < 5; i++) begin
            n_cmp += 2;
            if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL hold_tvalid: got %b, expected 1", m_axis_tvalid); end
            if (m_axis_tdata !== 8'h00) begin n_fail++; $display("FAIL hold_tdata: got %h, expected 00", m_axis_tdata); end
            tick();
        end
        m_axis_tready = 1'b1;
        tick();
        n_cmp += 2;
        if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_tvalid: got %b, expected 1", m_axis_tvalid); end
        if (m_axis_tdata !== 8'h31) begin n_fail++; $display("FAIL b2b_tdata: got %h, expected 31", m_axis_tdata); end
        tick();
        n_cmp++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_done: got %b, expected 0", m_axis_tvalid); end
        wait_drain(4);
    endtask

    task automatic test_errors();
        do_reset();
        m_axis_tready = 1'b1;
        complete_i = 1'b1; err_i = 4'hF; tick();
        n_cmp += 2;
        if (status_err_o !== 3'b010) begin n_fail++; $display("FAIL err_cmp_flag: got %b, expected 010", status_err_o); end
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL err_cmp_nobeat: got %b, expected 0", m_axis_tvalid); end
        tick();
        free_i = 1'b1; tick();
        n_cmp += 2;
        if (status_err_o !== 3'b110) begin n_fail++; $display("FAIL err_free_flag: got %b, expected 110", status_err_o); end
        if (occupancy_o !== 3'd0) begin n_fail++; $display("FAIL err_free_occ: got %0d, expected 0", occupancy_o); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        m_axis_tready = 1'b1;
        alloc_i = 1'b1; complete_i = 1'b1; err_i = 4'h5; exp_q.push_back(8'h50); tick();
        n_cmp += 3;
        if (occupancy_o !== 3'd1) begin n_fail++; $display("FAIL simul_occ: got %0d, expected 1", occupancy_o); end
        if (status_err_o !== 3'b000) begin n_fail++; $display("FAIL simul_status: got %b, expected 000", status_err_o); end
        if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL simul_tvalid: got %b, expected 1", m_axis_tvalid); end
        tick();
        free_i = 1'b1; tick();
        wait_drain(4);
        for (int i = 0; i < 4; i++) begin
            alloc_i = 1'b1; complete_i = 1'b1; err_i = 4'(i + 8);
            exp_q.push_back(beat(4'(i + 8), 2'(i + 1)));
            tick();
        end
        wait_drain(6);
        n_cmp++;
        if (occupancy_o !== 3'd4) begin n_fail++; $display("FAIL full_occ: got %0d, expected 4", occupancy_o); end
        free_i = 1'b1; alloc_i = 1'b1; tick();
        n_cmp += 2;
        if (occupancy_o !== 3'd3) begin n_fail++; $display("FAIL full_free_alloc_occ: got %0d, expected 3", occupancy_o); end
        if (status_err_o !== 3'b001) begin n_fail++; $display("FAIL full_free_alloc_flag: got %b, expected 001", status_err_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (alloc_idx_o !== 2'(i)) begin n_fail++; $display("FAIL wrap_idx: got %0d, expected %0d", alloc_idx_o, i % 4); end
            alloc_i = 1'b1; complete_i = 1'b1; err_i = 4'(i);
            exp_q.push_back(beat(4'(i), 2'(i)));
            free_i = (i >= 2);
            tick();
        end
        free_i = 1'b1; tick();
        free_i = 1'b1; tick();
        wait_drain(4);
        n_cmp += 2;
        if (occupancy_o !== 3'd0) begin n_fail++; $display("FAIL wrap_occ: got %0d, expected 0", occupancy_o); end
        if (status_err_o !== 3'b000) begin n_fail++; $display("FAIL wrap_status: got %b, expected 000", status_err_o); end
    endtask

    task automatic test_reset_mid();
        m_axis_tready = 1'b0;
        alloc_i = 1'b1; tick();
        alloc_i = 1'b1; tick();
        complete_i = 1'b1; err_i = 4'h2; tick();
        complete_i = 1'b1; err_i = 4'h4; tick();
        n_cmp++;
        if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL mid_pending: got %b, expected 1", m_axis_tvalid); end
        aresetn = 1'b0; tick();
        n_cmp += 2;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_tvalid: got %b, expected 0", m_axis_tvalid); end
        if (occupancy_o !== 3'd0) begin n_fail++; $display("FAIL mid_rst_occ: got %0d, expected 0", occupancy_o); end
        aresetn = 1'b1; tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stream();
        test_back_to_back();
        test_errors();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        n_cmp++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_beats: got %0d, expected 0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
